// File: rtl/axil_map_mem_if.sv
// AXI-lite-style channel bundle for axil_map_mem: AR/R read channels, AW/W/B write channels.
interface axil_map_mem_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [DATA_W-1:0] r_data;
    logic              r_err;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_valid;
    logic              aw_ready;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic              w_ready;
    logic              b_err;
    logic              b_valid;
    logic              b_ready;

    modport master (
        output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid, b_ready,
        input  ar_ready, r_data, r_err, r_valid, aw_ready, w_ready, b_err, b_valid
    );

    modport slave (
        input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_valid, b_ready,
        output ar_ready, r_data, r_err, r_valid, aw_ready, w_ready, b_err, b_valid
    );
endinterface

// File: rtl/axil_map_mem.sv
// Memory-mapped RAM slave: reads return stored word + OFFSET through a small in-order FIFO.
// Optional bounds checking is enabled by defining AXIL_MAP_BOUNDS_EN.
module axil_map_mem #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned OFFSET      = 3,
    parameter int unsigned RFIFO_DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    axil_map_mem_if.slave bus
);
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PtrW = $clog2(RFIFO_DEPTH);
    localparam int unsigned CntW = $clog2(RFIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [IdxW-1:0]   w_idx, r_idx;
    logic              wr_oor, rd_oor;
    logic              wr_fire, wr_en, ar_fire;
    logic              b_valid_q, b_err_q;
    logic              rd_vld_q, rd_err_q;
    logic [DATA_W-1:0] rd_data_q, rd_word;

    logic [DATA_W:0]   fifo_q [RFIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [CntW:0]     occ;
    logic              push, pop;

    assign w_idx = bus.aw_addr[IdxW-1:0];
    assign r_idx = bus.ar_addr[IdxW-1:0];

`ifdef AXIL_MAP_BOUNDS_EN
    localparam logic [ADDR_W:0] DepthL = (ADDR_W + 1)'(DEPTH);
    assign wr_oor = ({1'b0, bus.aw_addr} >= DepthL);
    assign rd_oor = ({1'b0, bus.ar_addr} >= DepthL);
`else
    logic unused_addr;
    assign unused_addr = ^{bus.ar_addr, bus.aw_addr};
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
`endif

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(RFIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Write path: AW and W are taken together, only when the B slot is free or draining.
    assign wr_fire      = !rst && bus.aw_valid && bus.w_valid && (!b_valid_q || bus.b_ready);
    assign wr_en        = wr_fire && !wr_oor;
    assign bus.aw_ready = wr_fire;
    assign bus.w_ready  = wr_fire;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_err    = b_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_q <= 1'b0;
            b_err_q   <= 1'b0;
        end else if (wr_fire) begin
            b_valid_q <= 1'b1;
            b_err_q   <= wr_oor;
        end else if (bus.b_ready) begin
            b_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[w_idx] <= bus.w_data;
        end
    end

    // Write-first: a same-edge write to the read address is forwarded to the read.
    assign rd_word = (wr_en && (w_idx == r_idx)) ? bus.w_data : mem_q[r_idx];

    // Credit check counts the in-flight read so the FIFO can never overflow.
    assign push         = rd_vld_q;
    assign pop          = bus.r_valid && bus.r_ready;
    assign occ          = {1'b0, cnt_q} + (CntW + 1)'(rd_vld_q) - (CntW + 1)'(pop);
    assign ar_fire      = bus.ar_valid && bus.ar_ready;
    assign bus.ar_ready = !rst && (occ < (CntW + 1)'(RFIFO_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= ar_fire;
            if (ar_fire) begin
                rd_err_q  <= rd_oor;
                rd_data_q <= rd_oor ? '0 : rd_word + DATA_W'(OFFSET);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {rd_err_q, rd_data_q};
        end
    end

    assign bus.r_valid = (cnt_q != '0);
    assign bus.r_data  = fifo_q[rptr_q][DATA_W-1:0];
    assign bus.r_err   = bus.r_valid && fifo_q[rptr_q][DATA_W];
endmodule

// File: tb/tb_axil_map_mem.sv
// Self-checking bench for axil_map_mem: vector table, sweep, throughput, backpressure,
// hazard ordering, mid-stream reset and address bounds/wrap on a 512-word instance.
`timescale 1ns/1ps
module tb_axil_map_mem;
`ifdef AXIL_MAP_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_map_mem_if #(.DATA_W(32), .ADDR_W(10)) bus ();
    axil_map_mem_if #(.DATA_W(32), .ADDR_W(10)) bus2 ();

    axil_map_mem #(
        .DATA_W(32), .ADDR_W(10), .DEPTH(1024), .OFFSET(3), .RFIFO_DEPTH(2)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    axil_map_mem #(
        .DATA_W(32), .ADDR_W(10), .DEPTH(512), .OFFSET(3), .RFIFO_DEPTH(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int r_cnt = 0;
    int b_cnt = 0;
    logic [31:0] model [1024];
    logic [31:0] exp_q [$];
    logic [31:0] rx_q [$];

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard: handshakes are observed at the negedge before the edge that commits them.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.aw_valid && bus.aw_ready) model[bus.aw_addr] = bus.w_data;
            if (bus.ar_valid && bus.ar_ready) exp_q.push_back(model[bus.ar_addr] + 32'd3);
            if (bus.r_valid && bus.r_ready) begin
                r_cnt++;
                rx_q.push_back(bus.r_data);
                if (exp_q.size() == 0) begin
                    check("r_unexpected", exp_q.size(), 1);
                end else begin
                    check("r_data", bus.r_data, exp_q.pop_front());
                    check("r_err", {31'd0, bus.r_err}, 32'd0);
                end
            end
            if (bus.b_valid && bus.b_ready) b_cnt++;
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        int n = 0;
        bus.aw_addr = a; bus.w_data = d; bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.aw_ready && n < 50);
        if (!bus.aw_ready) check("aw_timeout", {31'd0, bus.aw_ready}, 32'd1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        int n = 0;
        bus.ar_addr = a; bus.ar_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus.ar_ready && n < 50);
        if (!bus.ar_ready) check("ar_timeout", {31'd0, bus.ar_ready}, 32'd1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
    endtask

    task automatic rd_get(input logic [9:0] a, output logic [31:0] d, output logic e);
        int n = 0;
        rd(a);
        do begin @(negedge clk); n++; end while (!bus.r_valid && n < 50);
        check("r_timeout", {31'd0, bus.r_valid}, 32'd1);
        d = bus.r_data; e = bus.r_err;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.b_valid) && n < 200) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wr2(input logic [9:0] a, input logic [31:0] d, output logic e);
        int n = 0;
        bus2.aw_addr = a; bus2.w_data = d; bus2.aw_valid = 1'b1; bus2.w_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus2.aw_ready && n < 50);
        @(posedge clk); #1;
        bus2.aw_valid = 1'b0; bus2.w_valid = 1'b0;
        n = 0;
        while (!bus2.b_valid && n < 50) begin @(negedge clk); n++; end
        check("b2_timeout", {31'd0, bus2.b_valid}, 32'd1);
        e = bus2.b_err;
        @(posedge clk); #1;
    endtask

    task automatic rd2(input logic [9:0] a, output logic [31:0] d, output logic e);
        int n = 0;
        bus2.ar_addr = a; bus2.ar_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!bus2.ar_ready && n < 50);
        @(posedge clk); #1;
        bus2.ar_valid = 1'b0;
        n = 0;
        while (!bus2.r_valid && n < 50) begin @(negedge clk); n++; end
        check("r2_timeout", {31'd0, bus2.r_valid}, 32'd1);
        d = bus2.r_data; e = bus2.r_err;
        @(posedge clk); #1;
    endtask

    initial begin
        int stalls, gaps, acc, k, b0, r0;
        logic [31:0] got;
        logic gerr;

        vecs[0] = '{10'd5,    32'd100,        32'd103};
        vecs[1] = '{10'd7,    32'hFFFF_FFFF,  32'd2};
        vecs[2] = '{10'd0,    32'd0,          32'd3};
        vecs[3] = '{10'd1023, 32'hFFFF_FFFD,  32'd0};
        vecs[4] = '{10'd512,  32'h0000_1234,  32'h0000_1237};
        vecs[5] = '{10'd1,    32'hFFFF_FFFE,  32'd1};

        // Valids held high during reset so the ready checks mean something.
        bus.ar_addr = '0; bus.aw_addr = '0; bus.w_data = '0;
        bus.ar_valid = 1'b1; bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        bus.r_ready = 1'b1; bus.b_ready = 1'b1;
        bus2.ar_addr = '0; bus2.aw_addr = '0; bus2.w_data = '0;
        bus2.ar_valid = 1'b0; bus2.aw_valid = 1'b0; bus2.w_valid = 1'b0;
        bus2.r_ready = 1'b1; bus2.b_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_r_valid",  {31'd0, bus.r_valid},  32'd0);
        check("rst_b_valid",  {31'd0, bus.b_valid},  32'd0);
        check("rst_r_err",    {31'd0, bus.r_err},    32'd0);
        check("rst_b_err",    {31'd0, bus.b_err},    32'd0);
        check("rst_ar_ready", {31'd0, bus.ar_ready}, 32'd0);
        check("rst_aw_ready", {31'd0, bus.aw_ready}, 32'd0);
        check("rst_w_ready",  {31'd0, bus.w_ready},  32'd0);
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        foreach (vecs[i]) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd_get(vecs[i].addr, got, gerr);
            check("vec_data", got, vecs[i].exp);
            check("vec_err", {31'd0, gerr}, 32'd0);
        end
        drain();

        b0 = b_cnt; r0 = r_cnt;
        for (int i = 0; i < 1024; i++) begin
            wr(10'(i), 32'(i));
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        for (int i = 0; i < 1024; i++) rd(10'(i));
        drain();
        check("sweep_b_cnt", b_cnt - b0, 1024);
        check("sweep_r_cnt", r_cnt - r0, 1024);

        stalls = 0; gaps = 0;
        for (int i = 0; i < 16; i++) begin
            bus.ar_addr = 10'(i); bus.ar_valid = 1'b1;
            @(negedge clk);
            if (!bus.ar_ready) stalls++;
            if (i >= 2 && !bus.r_valid) gaps++;
            @(posedge clk); #1;
        end
        bus.ar_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (!bus.r_valid) gaps++;
            @(posedge clk); #1;
        end
        check("tput_stalls", stalls, 0);
        check("tput_gaps", gaps, 0);
        drain();

        bus.r_ready = 1'b0; acc = 0; r0 = r_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.ar_addr = 10'(20 + acc); bus.ar_valid = 1'b1;
            @(negedge clk);
            if (bus.ar_ready) acc++;
            @(posedge clk); #1;
        end
        bus.ar_valid = 1'b0;
        check("bp_accepts", acc, 2);
        check("bp_r_valid", {31'd0, bus.r_valid}, 32'd1);
        check("bp_head", bus.r_data, 32'd23);
        bus.r_ready = 1'b1;
        drain();
        check("bp_delivered", r_cnt - r0, 2);

        wr(10'd5, 32'd50);
        idle(2);
        bus.ar_addr = 10'd5; bus.ar_valid = 1'b1;
        @(negedge clk);
        check("hz_ar_old", {31'd0, bus.ar_ready}, 32'd1);
        @(posedge clk); #1;
        bus.aw_addr = 10'd5; bus.w_data = 32'd100; bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
        @(negedge clk);
        check("hz_ar_new", {31'd0, bus.ar_ready}, 32'd1);
        check("hz_aw", {31'd0, bus.aw_ready}, 32'd1);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
        drain();
        k = rx_q.size();
        check("hz_old_data", rx_q[k-2], 32'd53);
        check("hz_new_data", rx_q[k-1], 32'd103);

        bus.b_ready = 1'b0;
        wr(10'd9, 32'd900);
        bus.r_ready = 1'b0;
        bus.ar_addr = 10'd9; bus.ar_valid = 1'b1;
        @(posedge clk); #1;
        bus.ar_addr = 10'd10;
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        check("pre_rst_r_valid", {31'd0, bus.r_valid}, 32'd1);
        check("pre_rst_b_valid", {31'd0, bus.b_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_r_valid", {31'd0, bus.r_valid}, 32'd0);
        check("mid_rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.r_ready = 1'b1; bus.b_ready = 1'b1;
        b0 = b_cnt; r0 = r_cnt;
        idle(3);
        check("post_rst_no_b", b_cnt - b0, 0);
        check("post_rst_no_r", r_cnt - r0, 0);
        rd_get(10'd9, got, gerr);
        check("post_rst_data", got, 32'd903);
        drain();

        wr2(10'd88, 32'h0000_00AA, gerr);
        check("b2_err_in", {31'd0, gerr}, 32'd0);
        wr2(10'd600, 32'h0000_0055, gerr);
        check("b2_err_oor", {31'd0, gerr}, BoundsEn ? 32'd1 : 32'd0);
        rd2(10'd88, got, gerr);
        check("r2_data_88", got, BoundsEn ? 32'h0000_00AD : 32'h0000_0058);
        check("r2_err_88", {31'd0, gerr}, 32'd0);
        rd2(10'd600, got, gerr);
        check("r2_data_600", got, BoundsEn ? 32'd0 : 32'h0000_0058);
        check("r2_err_600", {31'd0, gerr}, BoundsEn ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
        $fatal(1);
    end
endmodule
